// File: rtl/sd_pkg.sv
// Shared SD host definitions: CMD/DAT framing constants and CRC7 next-state helpers.
// Combinational helpers only; no state, no latency.
// No flow control; callers gate the shift themselves.
package sd_pkg;

    // CMD-line CRC7: G(x) = x^7 + x^3 + 1, zero seed, MSB first.
    localparam int          SD_CRC7_W           = 7;
    localparam logic [6:0]  SD_CRC7_POLY        = 7'h09;
    localparam logic [6:0]  SD_CRC7_INIT        = 7'h00;

    // A command frame is 48 bits; the CRC covers the first 40 (start, dir, index, arg).
    localparam int          SD_CMD_FRAME_BITS   = 48;
    localparam int          SD_CMD_CONTENT_BITS = 40;

    // One serial CRC7 step with an arbitrary tap set (x^7 term implied).
    // The incoming bit is XORed with the outgoing MSB; if the result is set,
    // the taps are folded into the shifted remainder.
    function automatic logic [6:0] crc7_step(
        input logic [6:0] crc,
        input logic       bit_in,
        input logic [6:0] poly
    );
        logic inv;
        inv = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (inv ? poly : 7'h00);
    endfunction

    // Standard SD CMD-line CRC7 step (x^3 + 1 taps).
    function automatic logic [6:0] crc7_next(
        input logic [6:0] crc,
        input logic       bit_in
    );
        return crc7_step(crc, bit_in, SD_CRC7_POLY);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 generator/checker for the SD CMD line (MSB first, zero seed).
// Latency: 1 cycle; CRC shows every bit shifted up to and including the previous edge.
// No backpressure: ENABLE gates each shift, CLEAR reseeds and overrides ENABLE.
module sd_crc7
    import sd_pkg::*;
#(
    parameter int               CRC_W = SD_CRC7_W,
    parameter logic [CRC_W-1:0] POLY  = SD_CRC7_POLY,
    parameter logic [CRC_W-1:0] INIT  = SD_CRC7_INIT
) (
    input  logic             SD_CLK_IN,
    input  logic             RST_IN,
    input  logic             BITVAL,
    input  logic             ENABLE,
    input  logic             CLEAR,
    output logic [CRC_W-1:0] CRC
);

    logic [CRC_W-1:0] crc_d;
    logic [CRC_W-1:0] crc_q;

    // Next remainder: CLEAR wins, then ENABLE shifts; BITVAL is never looked at
    // while idle, so an undriven serial line cannot disturb a finished result.
    always_comb begin
        crc_d = crc_q;
        if (CLEAR) begin
            crc_d = INIT;
        end else if (ENABLE) begin
            crc_d = crc7_step(crc_q, BITVAL, POLY);
        end
    end

    // Remainder register; reset is asynchronous so a mid-frame abort drops the partial CRC at once.
    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    // CRC[6] is the first bit the host serialises after the frame content.
    assign CRC = crc_q;

endmodule

// File: tb/tb_sd_crc7.sv
// Self-checking bench for sd_crc7: directed SD command vectors plus random frames
// checked against a polynomial long-division model of CRC7.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_sd_crc7;

    logic       SD_CLK_IN;
    logic       RST_IN;
    logic       BITVAL;
    logic       ENABLE;
    logic       CLEAR;
    logic [6:0] CRC;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected value, compare mode (1 = must differ), check name.
    logic [6:0] exp_q[$];
    bit         ne_q[$];
    string      name_q[$];

    bit frame_q[$];

    sd_crc7 dut (
        .SD_CLK_IN (SD_CLK_IN),
        .RST_IN    (RST_IN),
        .BITVAL    (BITVAL),
        .ENABLE    (ENABLE),
        .CLEAR     (CLEAR),
        .CRC       (CRC)
    );

    initial SD_CLK_IN = 1'b0;
    always #5 SD_CLK_IN = ~SD_CLK_IN;

    // Reference: remainder of M(x) * x^7 divided by x^7 + x^3 + 1, by long division.
    function automatic logic [6:0] ref_crc(input bit b[$]);
        bit         w[$];
        logic [7:0] g;
        logic [6:0] r;
        int         n;
        n = b.size();
        w = b;
        repeat (7) w.push_back(1'b0);
        g = 8'h89;
        for (int i = 0; i < n; i++) begin
            if (w[i]) begin
                for (int j = 0; j < 8; j++) begin
                    w[i+j] = w[i+j] ^ g[7-j];
                end
            end
        end
        for (int k = 0; k < 7; k++) begin
            r[6-k] = w[n+k];
        end
        return r;
    endfunction

    task automatic expect_crc(input logic [6:0] e, input bit ne, input string nm);
        exp_q.push_back(e);
        ne_q.push_back(ne);
        name_q.push_back(nm);
    endtask

    // Monitor: one pending expectation is compared per falling edge.
    logic [6:0] mon_exp;
    bit         mon_ne;
    string      mon_name;
    bit         mon_ok;
    always @(negedge SD_CLK_IN) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_ne   = ne_q.pop_front();
            mon_name = name_q.pop_front();
            checks++;
            if (mon_ne) mon_ok = (CRC !== mon_exp) && !$isunknown(CRC);
            else        mon_ok = (CRC === mon_exp);
            if (!mon_ok) begin
                errors++;
                $display("FAIL %s: crc=%h required %s%h", mon_name, CRC,
                         mon_ne ? "not " : "", mon_exp);
            end
        end
    end

    // All drives happen 1 time unit after a rising edge.
    task automatic tick();
        @(posedge SD_CLK_IN);
        #1;
    endtask

    task automatic load_word(input logic [39:0] v);
        frame_q.delete();
        for (int i = 39; i >= 0; i--) frame_q.push_back(v[i]);
    endtask

    // Shift the first n bits of frame_q, optionally with random idle gaps.
    task automatic send_bits(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    ENABLE = 1'b0;
                    BITVAL = 1'($urandom);
                    tick();
                end
            end
            ENABLE = 1'b1;
            BITVAL = frame_q[i];
            tick();
        end
        ENABLE = 1'b0;
        BITVAL = 1'($urandom);
    endtask

    task automatic do_clear();
        CLEAR  = 1'b1;
        ENABLE = 1'b0;
        tick();
        CLEAR  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] v;
        logic [6:0]  crc17;
        int          gap;

        RST_IN = 1'b1;
        BITVAL = 1'b0;
        ENABLE = 1'b0;
        CLEAR  = 1'b0;
        repeat (2) tick();
        expect_crc(7'h00, 1'b0, "reset_init");
        tick();
        RST_IN = 1'b0;
        tick();

        // Asynchronous reset in the middle of a frame.
        load_word(40'h48_0000_01AA);
        send_bits(12, 0);
        begin
            bit part[$];
            for (int i = 0; i < 12; i++) part.push_back(frame_q[i]);
            expect_crc(ref_crc(part), 1'b0, "partial_frame");
        end
        tick();
        ENABLE = 1'b1;
        BITVAL = 1'b1;
        #1 RST_IN = 1'b1;
        #1 expect_crc(7'h00, 1'b0, "async_reset");
        repeat (3) begin
            tick();
            expect_crc(7'h00, 1'b0, "reset_held");
        end
        tick();
        RST_IN = 1'b0;
        ENABLE = 1'b0;
        tick();

        // Known command CRCs.
        do_clear();
        load_word(40'h40_0000_0000);
        send_bits(40, 0);
        expect_crc(7'h4A, 1'b0, "cmd0");
        tick();
        do_clear();
        load_word(40'h48_0000_01AA);
        send_bits(40, 0);
        expect_crc(7'h43, 1'b0, "cmd8");
        tick();
        do_clear();
        load_word(40'h51_0000_0000);
        send_bits(40, 0);
        expect_crc(7'h2A, 1'b0, "cmd17");
        tick();

        // Gated shifting with random idle cycles, then a long hold.
        do_clear();
        load_word(40'h40_0000_0000);
        send_bits(40, 3);
        expect_crc(7'h4A, 1'b0, "cmd0_gap");
        repeat (10) begin
            ENABLE = 1'b0;
            BITVAL = 1'($urandom);
            tick();
            expect_crc(7'h4A, 1'b0, "hold");
        end

        // CLEAR beats ENABLE on the same edge; next frame starts clean.
        load_word(40'h48_0000_01AA);
        send_bits(20, 0);
        CLEAR  = 1'b1;
        ENABLE = 1'b1;
        BITVAL = 1'b1;
        tick();
        CLEAR  = 1'b0;
        ENABLE = 1'b0;
        expect_crc(7'h00, 1'b0, "clear_prio");
        load_word(40'h40_0000_0000);
        send_bits(40, 0);
        expect_crc(7'h4A, 1'b0, "cmd0_after_clear");
        tick();

        // Whole-frame check: data plus its CRC leaves a zero remainder.
        crc17 = 7'h2A;
        do_clear();
        load_word(40'h51_0000_0000);
        for (int i = 6; i >= 0; i--) frame_q.push_back(crc17[i]);
        send_bits(47, 0);
        expect_crc(7'h00, 1'b0, "selfcheck");
        tick();
        for (int k = 0; k < 47; k++) begin
            do_clear();
            load_word(40'h51_0000_0000);
            for (int i = 6; i >= 0; i--) frame_q.push_back(crc17[i]);
            frame_q[k] = !frame_q[k];
            send_bits(47, 0);
            expect_crc(7'h00, 1'b1, "flip");
            tick();
        end

        // Random 40-bit frames against the division model.
        repeat (1000) begin
            do_clear();
            v[39:32] = 8'($urandom);
            v[31:0]  = $urandom;
            load_word(v);
            gap = ($urandom_range(0, 7) == 0) ? 2 : 0;
            send_bits(40, gap);
            expect_crc(ref_crc(frame_q), 1'b0, "random");
            tick();
        end

        tick();
        tick();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
